// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweeper: drives all 16 input vectors of a 4-input unit, samples its
// output after SETTLE cycles per vector, and compares the captured table to a golden one.
module tt_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth,
  output logic [4:0]  ones,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);

  state_t     state;
  logic [3:0] vec;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vec    <= 4'h0;
      cnt    <= 8'h00;
      dut_in <= 4'h0;
      busy   <= 1'b0;
      done   <= 1'b0;
      truth  <= 16'h0000;
      ones   <= 5'd0;
      pass   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= WAIT;
            vec    <= 4'h0;
            cnt    <= 8'h00;
            dut_in <= 4'h0;
            busy   <= 1'b1;
            truth  <= 16'h0000;
            ones   <= 5'd0;
            pass   <= 1'b0;
          end
        end
        WAIT: begin
          if (abort) begin
            state  <= IDLE;
            vec    <= 4'h0;
            cnt    <= 8'h00;
            dut_in <= 4'h0;
            busy   <= 1'b0;
            pass   <= 1'b0;
          end else if (cnt == LAST_CNT) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SAMPLE: begin
          // Abort wins over the capture, so the vector being sampled is dropped.
          if (abort) begin
            state  <= IDLE;
            vec    <= 4'h0;
            cnt    <= 8'h00;
            dut_in <= 4'h0;
            busy   <= 1'b0;
            pass   <= 1'b0;
          end else begin
            truth[vec] <= dut_out;
            ones       <= ones + {4'b0000, dut_out};
            cnt        <= 8'h00;
            if (vec == 4'hF) begin
              state  <= DONE;
              done   <= 1'b1;
              dut_in <= 4'h0;
            end else begin
              state  <= WAIT;
              vec    <= vec + 4'h1;
              dut_in <= vec + 4'h1;
            end
          end
        end
        DONE: begin
          pass  <= (truth == expected);
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: a behavioural 4-input unit feeds dut_out and
// every observation is checked with an immediate assertion against hand-derived values.
module tb_tt_sweep_ctrl;

  localparam int S = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic [3:0]  dut_in;
  logic        dut_out;
  logic        busy;
  logic        done;
  logic [15:0] truth;
  logic [4:0]  ones;
  logic        pass;

  int mode;
  int errors;
  int checks;
  int cyc;

  tt_sweep_ctrl #(.SETTLE(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .expected (expected),
    .dut_in   (dut_in),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .truth    (truth),
    .ones     (ones),
    .pass     (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit under sweep: 0 -> m=d, 1 -> m=a&b&c&d, 2 -> m=1.
  always_comb begin
    dut_out = 1'b0;
    case (mode)
      0:       dut_out = dut_in[0];
      1:       dut_out = &dut_in;
      default: dut_out = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Start edge then cycles 1..49, optionally re-pulsing start in two cycles; ends in cycle 50.
  task automatic run_sweep(input string tag, input int repulse_a, input int repulse_b);
    start = 1'b1;
    tick();
    cyc = 1;
    for (int c = 1; c <= 16 * (S + 1) + 1; c++) begin
      if (c > 1) tick();
      start = (c == repulse_a) || (c == repulse_b);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done"}, {31'd0, done}, (c == 16 * (S + 1) + 1) ? 32'd1 : 32'd0);
      chk({tag, "_dut_in"}, {28'd0, dut_in},
          (c <= 16 * (S + 1)) ? 32'((c - 1) / (S + 1)) : 32'd0);
    end
    start = 1'b0;
    tick();
    chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    mode     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    expected = 16'hAAAA;
    #1;
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_dut_in", {28'd0, dut_in}, 32'd0);
    chk("rst_truth",  {16'd0, truth},  32'd0);
    chk("rst_ones",   {27'd0, ones},   32'd0);
    chk("rst_pass",   {31'd0, pass},   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // m=d against 16'hAAAA: alternating table, eight ones, pass.
    mode = 0;
    expected = 16'hAAAA;
    run_sweep("d", 0, 0);
    chk("d_truth", {16'd0, truth}, 32'h0000AAAA);
    chk("d_ones",  {27'd0, ones},  32'd8);
    chk("d_pass",  {31'd0, pass},  32'd1);
    tick();
    tick();
    chk("d_hold_truth", {16'd0, truth}, 32'h0000AAAA);
    chk("d_hold_pass",  {31'd0, pass},  32'd1);

    // m=a&b&c&d against 16'h8001: only vector 15 is one, mismatch on bit 0.
    mode = 1;
    expected = 16'h8001;
    run_sweep("and", 0, 0);
    chk("and_truth", {16'd0, truth}, 32'h00008000);
    chk("and_ones",  {27'd0, ones},  32'd1);
    chk("and_pass",  {31'd0, pass},  32'd0);

    // m=1: full table and ones reaching 16.
    mode = 2;
    expected = 16'hFFFF;
    run_sweep("one", 0, 0);
    chk("one_truth", {16'd0, truth}, 32'h0000FFFF);
    chk("one_ones",  {27'd0, ones},  32'd16);
    chk("one_pass",  {31'd0, pass},  32'd1);

    // Start re-pulsed mid-sweep must not restart it.
    run_sweep("repulse", 5, 30);
    chk("repulse_truth", {16'd0, truth}, 32'h0000FFFF);
    chk("repulse_pass",  {31'd0, pass},  32'd1);

    // Abort in cycle 10 while vector 3 waits.
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) tick();
    chk("abort_vec3", {28'd0, dut_in}, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy",   {31'd0, busy},   32'd0);
    chk("abort_dut_in", {28'd0, dut_in}, 32'd0);
    chk("abort_truth",  {16'd0, truth},  32'h00000007);
    chk("abort_ones",   {27'd0, ones},   32'd3);
    chk("abort_pass",   {31'd0, pass},   32'd0);
    for (int i = 0; i < 45; i++) begin
      tick();
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("idle_abort_truth", {16'd0, truth}, 32'h00000007);
    chk("idle_abort_busy",  {31'd0, busy},  32'd0);

    // Asynchronous reset in cycle 20, released in cycle 23.
    mode = 0;
    expected = 16'hAAAA;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 20) tick();
    chk("pre_rst_truth", {16'd0, truth}, 32'h0000002A);
    chk("pre_rst_ones",  {27'd0, ones},  32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   {31'd0, busy},   32'd0);
    chk("arst_dut_in", {28'd0, dut_in}, 32'd0);
    chk("arst_truth",  {16'd0, truth},  32'd0);
    chk("arst_ones",   {27'd0, ones},   32'd0);
    chk("arst_pass",   {31'd0, pass},   32'd0);
    chk("arst_done",   {31'd0, done},   32'd0);
    while (cyc < 23) tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    run_sweep("post_rst", 0, 0);
    chk("post_rst_truth", {16'd0, truth}, 32'h0000AAAA);
    chk("post_rst_ones",  {27'd0, ones},  32'd8);
    chk("post_rst_pass",  {31'd0, pass},  32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
